// File: rtl/multiple_table_gen.sv
// Sequential builder of the 16-entry multiple table Mk = k * Multiplicand (mod 2^WIDTH).
// One add per cycle. The table is stable whenever TableValid is high.
module multiple_table_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Multiplicand,
  output logic             Busy,
  output logic             Done,
  output logic             TableValid,
  output logic [WIDTH-1:0] M0,
  output logic [WIDTH-1:0] M1,
  output logic [WIDTH-1:0] M2,
  output logic [WIDTH-1:0] M3,
  output logic [WIDTH-1:0] M4,
  output logic [WIDTH-1:0] M5,
  output logic [WIDTH-1:0] M6,
  output logic [WIDTH-1:0] M7,
  output logic [WIDTH-1:0] M8,
  output logic [WIDTH-1:0] M9,
  output logic [WIDTH-1:0] M10,
  output logic [WIDTH-1:0] M11,
  output logic [WIDTH-1:0] M12,
  output logic [WIDTH-1:0] M13,
  output logic [WIDTH-1:0] M14,
  output logic [WIDTH-1:0] M15
);

  typedef enum logic [0:0] {StIdle, StBuild} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  // Entry 0 is held at zero and never written; it only feeds nothing but keeps indexing uniform.
  logic [WIDTH-1:0] tbl_q [16];
  logic [WIDTH-1:0] tbl_d [16];

  // Next-state: accept Start in idle, otherwise extend the table by one entry per cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mc_d    = mc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    tbl_d   = tbl_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          mc_d     = Multiplicand;
          tbl_d[1] = Multiplicand;
          for (int k = 2; k < 16; k++) tbl_d[k] = '0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          idx_d    = 4'd2;
          state_d  = StBuild;
        end
      end
      StBuild: begin
        // Carry out of the add is intentionally dropped: entries wrap mod 2^WIDTH.
        tbl_d[idx_q] = tbl_q[idx_q - 4'd1] + mc_q;
        idx_d        = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          idx_d   = 4'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset taking priority over Start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      mc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int k = 0; k < 16; k++) tbl_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mc_q    <= mc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      for (int k = 0; k < 16; k++) tbl_q[k] <= tbl_d[k];
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign TableValid = valid_q;
  assign M0         = '0;
  assign M1         = tbl_q[1];
  assign M2         = tbl_q[2];
  assign M3         = tbl_q[3];
  assign M4         = tbl_q[4];
  assign M5         = tbl_q[5];
  assign M6         = tbl_q[6];
  assign M7         = tbl_q[7];
  assign M8         = tbl_q[8];
  assign M9         = tbl_q[9];
  assign M10        = tbl_q[10];
  assign M11        = tbl_q[11];
  assign M12        = tbl_q[12];
  assign M13        = tbl_q[13];
  assign M14        = tbl_q[14];
  assign M15        = tbl_q[15];

endmodule

// File: tb/tb_multiple_table_gen.sv
// Directed bench for multiple_table_gen with hand-computed expected table entries.
module tb_multiple_table_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] Multiplicand;
  logic        Busy, Done, TableValid;
  logic [31:0] M0, M1, M2, M3, M4, M5, M6, M7, M8, M9, M10, M11, M12, M13, M14, M15;

  int nvec = 0;
  int nerr = 0;
  int edges;

  multiple_table_gen #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Multiplicand(Multiplicand),
    .Busy(Busy), .Done(Done), .TableValid(TableValid),
    .M0(M0), .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6), .M7(M7),
    .M8(M8), .M9(M9), .M10(M10), .M11(M11), .M12(M12), .M13(M13), .M14(M14), .M15(M15)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge (edges already 1); counts edges until Done.
  task automatic wait_done(inout int n);
    while (Done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic start_build(input logic [31:0] mc, output int n);
    @(negedge clk);
    Start = 1'b1;
    Multiplicand = mc;
    @(posedge clk); #1;
    Start = 1'b0;
    n = 1;
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    Multiplicand = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m1", M1, 32'h0);
    chk("rst_m15", M15, 32'h0);
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_done", {31'b0, Done}, 32'h0);
    chk("rst_valid", {31'b0, TableValid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic build with multiplicand 3.
    start_build(32'd3, edges);
    chk("basic_busy_e0", {31'b0, Busy}, 32'h1);
    wait_done(edges);
    chk("basic_latency", edges, 32'd15);
    chk("basic_m0", M0, 32'd0);
    chk("basic_m1", M1, 32'd3);
    chk("basic_m7", M7, 32'd21);
    chk("basic_m15", M15, 32'd45);
    chk("basic_valid", {31'b0, TableValid}, 32'h1);
    chk("basic_busy", {31'b0, Busy}, 32'h0);
    @(posedge clk); #1;
    chk("basic_done_pulse", {31'b0, Done}, 32'h0);
    chk("basic_valid_hold", {31'b0, TableValid}, 32'h1);

    // Wraparound at 2^32.
    start_build(32'h2000_0000, edges);
    wait_done(edges);
    chk("ovf_latency", edges, 32'd15);
    chk("ovf_m7", M7, 32'hE000_0000);
    chk("ovf_m8", M8, 32'h0000_0000);
    chk("ovf_m15", M15, 32'hE000_0000);

    // All-ones multiplicand gives -k.
    start_build(32'hFFFF_FFFF, edges);
    wait_done(edges);
    chk("ones_m2", M2, 32'hFFFF_FFFE);
    chk("ones_m15", M15, 32'hFFFF_FFF1);

    // Start pulses during the build must be ignored.
    start_build(32'd5, edges);
    while (Done !== 1'b1 && edges < 40) begin
      if (edges == 5 || edges == 10) begin
        Start = 1'b1;
        Multiplicand = 32'd7;
      end else begin
        Start = 1'b0;
        Multiplicand = 32'd5;
      end
      @(posedge clk); #1;
      edges++;
    end
    Start = 1'b0;
    chk("ign_latency", edges, 32'd15);
    chk("ign_m1", M1, 32'd5);
    chk("ign_m15", M15, 32'd75);

    // Reset mid-build clears everything on the next edge.
    start_build(32'd4, edges);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_m1", M1, 32'h0);
    chk("mid_rst_m5", M5, 32'h0);
    chk("mid_rst_busy", {31'b0, Busy}, 32'h0);
    chk("mid_rst_done", {31'b0, Done}, 32'h0);
    chk("mid_rst_valid", {31'b0, TableValid}, 32'h0);
    start_build(32'd2, edges);
    wait_done(edges);
    chk("post_rst_latency", edges, 32'd15);
    chk("post_rst_m15", M15, 32'd30);

    // Start accepted in the Done cycle.
    start_build(32'd6, edges);
    wait_done(edges);
    chk("b2b_first_m15", M15, 32'd90);
    Start = 1'b1;
    Multiplicand = 32'd9;
    @(posedge clk); #1;
    Start = 1'b0;
    edges = 1;
    chk("b2b_done_fall", {31'b0, Done}, 32'h0);
    chk("b2b_busy", {31'b0, Busy}, 32'h1);
    chk("b2b_valid", {31'b0, TableValid}, 32'h0);
    chk("b2b_m1", M1, 32'd9);
    chk("b2b_m2_clear", M2, 32'd0);
    wait_done(edges);
    chk("b2b_latency", edges, 32'd15);
    chk("b2b_m15", M15, 32'd135);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
